pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the in-order core; it replaces the per-stage hand-written registers (decode→execute and similar).
- Carries an opaque payload bus with a valid/allow-in handshake and a flush input.
- SKID_EN selects the mode:
  - 0: single register.
  - 1: 2-entry skid buffer, so the upstream ready is a flop and does not depend combinationally on downstream allow-in.
- Also provides stage occupancy and a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 64, payload width in bits (the packed stage bundle).
- NOP_VALUE, {DATA_W{1'b0}}, payload value driven when the stage holds a bubble (carries the nop PC/instr/commit encodings).
- SKID_EN, 0, 0 = single-entry register; 1 = two-entry skid buffer.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush_i  in  1  kill all held and incoming entries this cycle
- up_valid_i  in  1  upstream stage has data (the "ready" of the previous generation)
- up_data_i  in  DATA_W  upstream payload
- up_allow_in_o  out  1  this stage accepts data this cycle
- dn_valid_o  out  1  payload to next stage is valid
- dn_data_o  out  DATA_W  payload to next stage
- dn_allow_in_i  in  1  next stage accepts this cycle
- occ_o  out  2  entries held (0..1 when SKID_EN=0, 0..2 when SKID_EN=1)
- stall_clr_i  in  1  synchronous clear of the stall counter
- stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and dn_allow_in_i=0

Behaviour:
- Transfer definitions: in_fire = up_valid_i & up_allow_in_o; out_fire = dn_valid_o & dn_allow_in_i.
- Reset (rst_n=0, asynchronous):
  - dn_valid_o=0, dn_data_o=NOP_VALUE, occ_o=0, stall_cnt_o=0.
  - Skid entry invalid and equal to NOP_VALUE.
  - up_allow_in_o=1 once reset is released.
- Flush has highest priority, evaluated at the clock edge:
  - All entries are invalidated and dn_data_o becomes NOP_VALUE.
  - A simultaneous in_fire is dropped.
  - The stall counter is unaffected.
- SKID_EN=0:
  - up_allow_in_o = ~dn_valid_o | dn_allow_in_i (combinational).
  - If in_fire: data is loaded and valid is set.
  - Else if dn_allow_in_i: valid is cleared and data becomes NOP_VALUE (bubble insertion).
  - Else: hold.
  - Latency is 1 cycle.
- SKID_EN=1: main entry M drives dn_*; skid entry S holds overflow. up_allow_in_o = ~S.valid (registered).
  - States:
    - EMPTY: M invalid.
    - ONE: M valid, S invalid.
    - FULL: both valid.
  - EMPTY:
    - in_fire → ONE (M ← in).
  - ONE:
    - in_fire & out_fire → ONE (M ← in).
    - in_fire & ~out_fire → FULL (S ← in).
    - ~in_fire & out_fire → EMPTY (M ← NOP_VALUE).
  - FULL (no input is accepted):
    - out_fire → ONE (M ← S, S ← NOP_VALUE).
  - Ordering and latency:
    - Strict FIFO order.
    - Latency is 1 cycle with no stall.
    - Full throughput of 1 per cycle is sustained.
- occ_o reflects registered state.
- Stall counter:
  - Increments when dn_valid_o & ~dn_allow_in_i.
  - Saturates at all-ones.
  - stall_clr_i wins over increment.
- Reset asserted mid-transfer: entries are discarded immediately; no partial payload is emitted.
- Payload is never modified; widths pass through bit-exact.

Decomposition:
- Shared package/define file holds the stage bundle widths (`PC_WIDTH, `XLEN, etc.) used to compute DATA_W.
- Shared package/define file also holds the NOP bundle constant (nop_PC, nop_nPC, nop_commit, nop_instr packed).
- One sub-module: pipe_skid_ctrl, containing the EMPTY/ONE/FULL control and enables. It is instantiated only when SKID_EN=1 (generate).
- The datapath flops stay in pipe_stage_reg.

Test Plan:
1. SKID_EN=0, dn_allow_in_i=1, up data 0x11,0x22,0x33 on consecutive cycles → dn_data_o 0x11,0x22,0x33 one cycle later each, dn_valid_o=1 throughout, stall_cnt_o=0.
2. SKID_EN=0, hold 0x55, dn_allow_in_i=0 for 3 cycles → up_allow_in_o=0, dn_data_o stays 0x55, stall_cnt_o=3. Then up_valid_i=0 with allow → dn_valid_o=0, dn_data_o=NOP_VALUE.
3. SKID_EN=1, dn_allow_in_i dropped while 0xA1,0xA2 arrive → occ_o=2, up_allow_in_o=0 next cycle. On release, outputs 0xA1 then 0xA2 in order, with no loss or duplication.
4. flush_i=1 in FULL state with up_valid_i=1 (0xEE) → next cycle dn_valid_o=0, occ_o=0, dn_data_o=NOP_VALUE, 0xEE never appears.
5. Stall counter with CNT_W=4: 20 stall cycles → stall_cnt_o=15 (saturated). stall_clr_i during a stall cycle → 0.
6. rst_n pulsed low asynchronously between edges while occ_o=2 → outputs reset immediately: dn_valid_o=0, stall_cnt_o=0. After release, up_allow_in_o=1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared stage-bundle layout and constants for the generic pipeline register.
// Also holds the skid-buffer state encoding and occupancy helper.
package pipe_stage_reg_pkg;

  localparam int PC_W     = 14;
  localparam int NPC_W    = 14;
  localparam int COMMIT_W = 4;
  localparam int INSTR_W  = 32;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [NPC_W-1:0]    npc;
    logic [COMMIT_W-1:0] commit;
    logic [INSTR_W-1:0]  instr;
  } stage_bundle_t;

  localparam int STAGE_W = $bits(stage_bundle_t);

  localparam logic [PC_W-1:0]     NOP_PC     = '0;
  localparam logic [NPC_W-1:0]    NOP_NPC    = '0;
  localparam logic [COMMIT_W-1:0] NOP_COMMIT = '0;
  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0]  NOP_INSTR  = 32'h0000_0013;

  localparam stage_bundle_t NOP_BUNDLE = '{
    pc:     NOP_PC,
    npc:    NOP_NPC,
    commit: NOP_COMMIT,
    instr:  NOP_INSTR
  };

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_count(
    input logic m_valid,
    input logic s_valid
  );
    return {m_valid & s_valid, m_valid ^ s_valid};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// EMPTY/ONE/FULL control for the two-entry skid buffer.
// Produces the main/skid load and clear enables; data flops live in the top.
module pipe_skid_ctrl
  import pipe_stage_reg_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n,
  input  logic flush_i,
  input  logic up_valid_i,
  input  logic dn_allow_in_i,
  output logic m_valid_o,
  output logic s_valid_o,
  output logic m_ld_in_o,
  output logic m_ld_s_o,
  output logic m_nop_o,
  output logic s_ld_in_o,
  output logic s_nop_o
);

  skid_state_e state_q, state_d;
  logic in_fire, out_fire;

  assign m_valid_o = (state_q != SKID_EMPTY);
  assign s_valid_o = (state_q == SKID_FULL);
  assign in_fire   = up_valid_i & ~s_valid_o;
  assign out_fire  = m_valid_o & dn_allow_in_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: if (in_fire) state_d = SKID_ONE;
        SKID_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = SKID_FULL;
          end else if (!in_fire && out_fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: if (out_fire) state_d = SKID_ONE;
        default:   state_d = SKID_EMPTY;
      endcase
    end
  end

  always_comb begin
    m_ld_in_o = 1'b0;
    m_ld_s_o  = 1'b0;
    m_nop_o   = flush_i;
    s_ld_in_o = 1'b0;
    s_nop_o   = flush_i;
    if (!flush_i) begin
      unique case (state_q)
        SKID_EMPTY: m_ld_in_o = in_fire;
        SKID_ONE: begin
          m_ld_in_o = in_fire & out_fire;
          s_ld_in_o = in_fire & ~out_fire;
          m_nop_o   = ~in_fire & out_fire;
        end
        SKID_FULL: begin
          m_ld_s_o = out_fire;
          s_nop_o  = out_fire;
        end
        default: m_nop_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: single entry or two-entry skid.
// Adds occupancy and a saturating stall counter for performance analysis.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = STAGE_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                SKID_EN   = 0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_allow_in_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_allow_in_i,
  output logic [1:0]        occ_o,
  input  logic              stall_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic m_valid, s_valid;
  logic m_ld_in, m_ld_s, m_nop;
  logic s_ld_in, s_nop;

  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  if (SKID_EN != 0) begin : g_skid
    pipe_skid_ctrl u_ctrl (
      .clk_i         (clk_i),
      .rst_n         (rst_n),
      .flush_i       (flush_i),
      .up_valid_i    (up_valid_i),
      .dn_allow_in_i (dn_allow_in_i),
      .m_valid_o     (m_valid),
      .s_valid_o     (s_valid),
      .m_ld_in_o     (m_ld_in),
      .m_ld_s_o      (m_ld_s),
      .m_nop_o       (m_nop),
      .s_ld_in_o     (s_ld_in),
      .s_nop_o       (s_nop)
    );
    assign up_allow_in_o = ~s_valid;
  end else begin : g_single
    logic valid_q, valid_d;
    logic in_fire;

    assign up_allow_in_o = ~valid_q | dn_allow_in_i;
    assign in_fire       = up_valid_i & up_allow_in_o;

    always_comb begin
      valid_d = valid_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (in_fire) begin
        valid_d = 1'b1;
      end else if (dn_allow_in_i) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign m_valid = valid_q;
    assign s_valid = 1'b0;
    assign m_ld_in = ~flush_i & in_fire;
    assign m_ld_s  = 1'b0;
    assign m_nop   = flush_i | (~in_fire & dn_allow_in_i);
    assign s_ld_in = 1'b0;
    assign s_nop   = 1'b1;
  end

  always_comb begin
    m_data_d = m_data_q;
    unique case (1'b1)
      m_nop:   m_data_d = NOP_VALUE;
      m_ld_in: m_data_d = up_data_i;
      m_ld_s:  m_data_d = s_data_q;
      default: m_data_d = m_data_q;
    endcase
  end

  always_comb begin
    s_data_d = s_data_q;
    unique case (1'b1)
      s_nop:   s_data_d = NOP_VALUE;
      s_ld_in: s_data_d = up_data_i;
      default: s_data_d = s_data_q;
    endcase
  end

  // Clear beats increment; the count sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (m_valid && !dn_allow_in_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q    <= NOP_VALUE;
      s_data_q    <= NOP_VALUE;
      stall_cnt_q <= '0;
    end else begin
      m_data_q    <= m_data_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dn_valid_o  = m_valid;
  assign dn_data_o   = m_data_q;
  assign occ_o       = occ_count(m_valid, s_valid);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a single-entry and a skid instance with shared stimulus and
// compares both against a small FIFO model of the handshake rules.
module tb_pipe_stage_reg;

  localparam int W = 16;
  localparam int CW = 4;
  localparam logic [W-1:0] NOP = 16'hDEAD;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic up_valid_i = 1'b0;
  logic [W-1:0] up_data_i = '0;
  logic dn_allow_in_i = 1'b0;
  logic stall_clr_i = 1'b0;

  logic allow0, allow1, dv0, dv1;
  logic [W-1:0] dd0, dd1;
  logic [1:0] occ0, occ1;
  logic [CW-1:0] sc0, sc1;

  int n_checks = 0;
  int n_errors = 0;

  // model: per mode a 2-deep FIFO (head at index 0) and a stall count
  logic [W-1:0] mem [2][2];
  int cnt [2];
  int stl [2];

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID_EN(0), .CNT_W(CW)) u_reg (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_data_i(up_data_i),
    .up_allow_in_o(allow0), .dn_valid_o(dv0), .dn_data_o(dd0),
    .dn_allow_in_i(dn_allow_in_i), .occ_o(occ0),
    .stall_clr_i(stall_clr_i), .stall_cnt_o(sc0)
  );

  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID_EN(1), .CNT_W(CW)) u_skid (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_data_i(up_data_i),
    .up_allow_in_o(allow1), .dn_valid_o(dv1), .dn_data_o(dd1),
    .dn_allow_in_i(dn_allow_in_i), .occ_o(occ1),
    .stall_clr_i(stall_clr_i), .stall_cnt_o(sc1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_allow(input int m);
    if (m == 0) return (cnt[0] == 0) || dn_allow_in_i;
    return cnt[1] < 2;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      stl[m] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e0, e1;
    e0 = (cnt[0] > 0) ? mem[0][0] : NOP;
    e1 = (cnt[1] > 0) ? mem[1][0] : NOP;
    chk({tag, ".r.valid"}, 32'(dv0), 32'(cnt[0] > 0));
    chk({tag, ".r.data"}, 32'(dd0), 32'(e0));
    chk({tag, ".r.occ"}, 32'(occ0), 32'(cnt[0]));
    chk({tag, ".r.stall"}, 32'(sc0), 32'(stl[0]));
    chk({tag, ".s.valid"}, 32'(dv1), 32'(cnt[1] > 0));
    chk({tag, ".s.data"}, 32'(dd1), 32'(e1));
    chk({tag, ".s.occ"}, 32'(occ1), 32'(cnt[1]));
    chk({tag, ".s.stall"}, 32'(sc1), 32'(stl[1]));
  endtask

  // Called at a negedge: apply inputs, check allow, advance model and clock.
  task automatic cycle(input string tag, input logic uv, input logic [W-1:0] ud,
                       input logic da, input logic fl, input logic clr);
    logic alw, inf, outf;
    up_valid_i = uv;
    up_data_i = ud;
    dn_allow_in_i = da;
    flush_i = fl;
    stall_clr_i = clr;
    #1;
    chk({tag, ".r.allow"}, 32'(allow0), 32'(exp_allow(0)));
    chk({tag, ".s.allow"}, 32'(allow1), 32'(exp_allow(1)));
    for (int m = 0; m < 2; m++) begin
      alw = exp_allow(m);
      inf = uv && alw;
      outf = (cnt[m] > 0) && da;
      if (clr) stl[m] = 0;
      else if (cnt[m] > 0 && !da && stl[m] < (1 << CW) - 1) stl[m]++;
      if (fl) begin
        cnt[m] = 0;
      end else begin
        if (outf) begin
          mem[m][0] = mem[m][1];
          cnt[m]--;
        end
        if (inf) begin
          mem[m][cnt[m]] = ud;
          cnt[m]++;
        end
      end
    end
    @(negedge clk_i);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    check_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("rst.r.allow", 32'(allow0), 32'd1);
    chk("rst.s.allow", 32'(allow1), 32'd1);
    @(negedge clk_i);

    // streaming at full rate
    cycle("t1a", 1, 16'h0011, 1, 0, 1);
    chk("t1.r.d11", 32'(dd0), 32'h11);
    cycle("t1b", 1, 16'h0022, 1, 0, 0);
    chk("t1.s.d22", 32'(dd1), 32'h22);
    cycle("t1c", 1, 16'h0033, 1, 0, 0);
    chk("t1.r.d33", 32'(dd0), 32'h33);
    chk("t1.s.d33", 32'(dd1), 32'h33);
    cycle("t1d", 0, 16'h0000, 1, 0, 0);
    chk("t1.r.bub", 32'(dd0), 32'(NOP));

    // stall while holding; skid fills to two
    cycle("t2a", 1, 16'h0055, 1, 0, 1);
    cycle("t2b", 1, 16'h0066, 0, 0, 0);
    cycle("t2c", 1, 16'h0077, 0, 0, 0);
    cycle("t2d", 1, 16'h0088, 0, 0, 0);
    chk("t2.r.hold", 32'(dd0), 32'h55);
    chk("t2.r.stall3", 32'(sc0), 32'd3);
    chk("t2.s.occ2", 32'(occ1), 32'd2);
    chk("t2.s.noallow", 32'(allow1), 32'd0);
    cycle("t2e", 0, 16'h0000, 1, 0, 0);
    chk("t2.r.nop", 32'(dd0), 32'(NOP));
    chk("t2.s.next", 32'(dd1), 32'h66);
    cycle("t2f", 0, 16'h0000, 1, 0, 0);

    // skid ordering A1 then A2, then flush with EE pending
    cycle("t3a", 1, 16'h00A1, 0, 0, 1);
    cycle("t3b", 1, 16'h00A2, 0, 0, 0);
    cycle("t3c", 1, 16'h00EE, 0, 1, 0);
    chk("t4.s.occ0", 32'(occ1), 32'd0);
    chk("t4.s.nop", 32'(dd1), 32'(NOP));
    cycle("t3d", 1, 16'h00A1, 0, 0, 0);
    cycle("t3e", 1, 16'h00A2, 0, 0, 0);
    cycle("t3f", 0, 16'h0000, 1, 0, 0);
    chk("t3.s.a2", 32'(dd1), 32'hA2);
    cycle("t3g", 0, 16'h0000, 1, 0, 0);

    // saturate the 4-bit stall counter, then clear mid-stall
    cycle("t5a", 1, 16'h0042, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle("t5s", 0, 16'h0000, 0, 0, 0);
    chk("t5.r.sat", 32'(sc0), 32'd15);
    chk("t5.s.sat", 32'(sc1), 32'd15);
    cycle("t5c", 0, 16'h0000, 0, 0, 1);
    chk("t5.s.clr", 32'(sc1), 32'd0);

    // async reset between edges with the skid full
    cycle("t6a", 1, 16'h0B01, 0, 0, 0);
    cycle("t6b", 1, 16'h0B02, 0, 0, 0);
    chk("t6.s.occ2", 32'(occ1), 32'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t6r");
    #1 rst_n = 1'b1;
    up_valid_i = 1'b0;
    dn_allow_in_i = 1'b0;
    #1;
    chk("t6.r.allow", 32'(allow0), 32'd1);
    chk("t6.s.allow", 32'(allow1), 32'd1);
    @(negedge clk_i);
    check_outputs("t6p");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd",
            $urandom_range(0, 9) < 7,
            W'($urandom),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
